traffic_light_ctrl: RTL and testbench
=====================================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter G_TIME, default 8, green duration in ticks (legal range 1..15).
REQ-002 Parameter Y_TIME, default 2, yellow duration in ticks (legal range 1..15).
REQ-003 Parameter AR_TIME, default 1, all-red duration in ticks (legal range 1..15).
REQ-004 clk_i  input  1  system clock; all state is updated on the rising edge of clk_i.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 slow_clk_i  input  1  divided clock from the clock divider, treated as asynchronous data.
REQ-007 ped_req_i  input  1  pedestrian button, level, asynchronous.
REQ-008 night_i  input  1  night-mode select, level, asynchronous.
REQ-009 ns_light_o  output  3  north-south lamps {R,Y,G}, one-hot, or 000 while flashing off.
REQ-010 ew_light_o  output  3  east-west lamps {R,Y,G}, same encoding as ns_light_o.
REQ-011 cnt_o  output  4  ticks remaining in the current state, for the 7-segment display.
REQ-012 state_o  output  3  current state code: NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5, FLASH=6.

Function
REQ-013 slow_clk_i, ped_req_i and night_i SHALL each pass through a 2-flop synchronizer.
REQ-014 tick SHALL be a one-clk_i pulse generated on each synchronized 0->1 edge of slow_clk_i; the pulse SHALL occur 3 cycles after the raw edge.
REQ-015 All state and cnt_o changes other than reset SHALL occur only on tick cycles.
REQ-016 Normal sequence: NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G.
REQ-017 On entering a state, cnt_o SHALL load that state's duration: G_TIME, Y_TIME or AR_TIME.
REQ-018 On a tick with cnt_o > 1, cnt_o SHALL decrement by 1.
REQ-019 On a tick with cnt_o == 1, the FSM SHALL advance to the next state and cnt_o SHALL load the next state's duration in the same cycle.
REQ-020 Lamps SHALL be set as follows:
- NS_G: NS=G, EW=R.
- NS_Y: NS=Y, EW=R.
- AR1 and AR2: NS=R, EW=R.
- EW_G: NS=R, EW=G.
- EW_Y: NS=R, EW=Y.
REQ-021 ped_pend SHALL be an internal flag set by the synchronized ped_req_i.
REQ-022 ped_pend SHALL clear on entry to AR1 or AR2; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-023 On a tick in NS_G or EW_G with ped_pend=1 and cnt_o > 2, cnt_o SHALL load 2 (shortened green) instead of decrementing.
REQ-024 On a tick in any non-FLASH state with night_i=1 (synchronized), the FSM SHALL enter FLASH and cnt_o SHALL be 0.
REQ-025 night_i SHALL take priority over ped_pend and over the normal advance.
REQ-026 In FLASH, an internal phase bit SHALL toggle on each tick; both lamp outputs SHALL be 010 when phase=1 and 000 when phase=0.
REQ-027 On entry to FLASH, phase SHALL be 1.
REQ-028 On a tick in FLASH with night_i=0, the FSM SHALL enter AR1 with cnt_o=AR_TIME, then continue the normal sequence to EW_G.
REQ-029 The FSM SHALL hold its state and count while slow_clk_i is stuck at either level.
REQ-030 Unused state codes SHALL recover to NS_G with cnt_o=G_TIME on the next clk_i edge.

Reset
REQ-031 While rst_i=1, the block SHALL force: state NS_G, cnt_o=G_TIME, ns_light_o=001, ew_light_o=100, ped_pend=0, phase=0, all synchronizer and edge-detect flops 0.
REQ-032 Reset SHALL take effect immediately, including mid-state and during FLASH.
REQ-033 After rst_i deasserts, the first tick SHALL require a fresh synchronized 0->1 edge; a slow_clk_i that is already high SHALL NOT produce a tick.

Verification
REQ-034 Reset, then 30 ticks with no requests -> states cycle 0,1,2,3,4,5,0:
- NS_G and EW_G last 8 ticks each, yellows 2, all-reds 1.
- cnt_o counts 8,7,...,1 during each green.
REQ-035 Pulse ped_req_i for 1 cycle while in NS_G with cnt_o=6 -> next tick gives cnt_o=2 -> NS_Y after 2 more ticks; ped_pend is 0 in AR1.
REQ-036 Pulse ped_req_i while in NS_G with cnt_o=2 -> no shortening; normal decrement to 1, then NS_Y.
REQ-037 Assert night_i during EW_G -> next tick gives state_o=6 and lamps 010/010; subsequent ticks alternate 000/000 and 010/010. Deassert night_i -> next tick gives AR1, cnt_o=1, then EW_G with cnt_o=8.
REQ-038 Assert night_i and ped_req_i together in NS_G -> FLASH entered and no green shortening.
REQ-039 Assert rst_i asynchronously mid-NS_Y with slow_clk_i high -> outputs return to the REQ-031 values within the same cycle; no tick until slow_clk_i falls and rises again.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller.
// A divided slow clock, sampled as ordinary data, paces the light sequence.
// A pending pedestrian request shortens the current green. Night mode
// overrides the normal sequence with a flashing yellow on both roads.
module traffic_light_ctrl #(
  parameter int G_TIME  = 8,
  parameter int Y_TIME  = 2,
  parameter int AR_TIME = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       slow_clk_i,
  input  logic       ped_req_i,
  input  logic       night_i,
  output logic [2:0] ns_light_o,
  output logic [2:0] ew_light_o,
  output logic [3:0] cnt_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_t;

  // Lamp encodings, {R,Y,G}.
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [3:0] G_CNT  = 4'(G_TIME);
  localparam logic [3:0] Y_CNT  = 4'(Y_TIME);
  localparam logic [3:0] AR_CNT = 4'(AR_TIME);

  // Synchronizers, edge detect and tick arming.
  logic [1:0] slow_sync;
  logic [1:0] ped_sync;
  logic [1:0] night_sync;
  logic       slow_prev;
  logic [1:0] sample_vld;
  logic       armed;
  logic       tick;
  logic       ped_s;
  logic       night_s;

  // FSM state and its next-state values.
  state_t     state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  logic       ped_pend_q, ped_pend_n;
  logic       phase_q, phase_n;

  // Synchronize the asynchronous inputs and build the tick pulse.
  // sample_vld marks when slow_sync[1] holds a real sample rather than its
  // reset value; only then can a low level arm the edge detector, so a
  // slow clock already high at reset release does not produce a tick.
  // NOTE: clocked blocks use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchronizer chain into a single flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slow_sync  <= 2'b00;
      ped_sync   <= 2'b00;
      night_sync <= 2'b00;
      slow_prev  <= 1'b0;
      sample_vld <= 2'b00;
      armed      <= 1'b0;
    end else begin
      slow_sync  <= {slow_sync[0], slow_clk_i};
      ped_sync   <= {ped_sync[0], ped_req_i};
      night_sync <= {night_sync[0], night_i};
      slow_prev  <= slow_sync[1];
      sample_vld <= {sample_vld[0], 1'b1};
      armed      <= armed | (sample_vld[1] & ~slow_sync[1]);
    end
  end

  assign tick    = slow_sync[1] & ~slow_prev & armed;
  assign ped_s   = ped_sync[1];
  assign night_s = night_sync[1];

  // Duration loaded on entry to each timed state.
  function automatic logic [3:0] dur(input state_t s);
    case (s)
      NS_G, EW_G: dur = G_CNT;
      NS_Y, EW_Y: dur = Y_CNT;
      default:    dur = AR_CNT;
    endcase
  endfunction

  // Successor in the normal six-state cycle.
  function automatic state_t next_of(input state_t s);
    case (s)
      NS_G:    next_of = NS_Y;
      NS_Y:    next_of = AR1;
      AR1:     next_of = EW_G;
      EW_G:    next_of = EW_Y;
      EW_Y:    next_of = AR2;
      default: next_of = NS_G;
    endcase
  endfunction

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= NS_G;
      cnt_q      <= G_CNT;
      ped_pend_q <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      ped_pend_q <= ped_pend_n;
      phase_q    <= phase_n;
    end
  end

  // Next-state logic: night mode first, then expiry, then pedestrian
  // shortening, otherwise a plain countdown. Nothing moves without a tick,
  // except recovery from an unused state code.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_n = state_q;
    cnt_n   = cnt_q;
    phase_n = phase_q;
    case (state_q)
      NS_G, NS_Y, AR1, EW_G, EW_Y, AR2: begin
        if (tick) begin
          if (night_s) begin
            state_n = FLASH;
            cnt_n   = 4'd0;
            phase_n = 1'b1;
          end else if (cnt_q <= 4'd1) begin
            state_n = next_of(state_q);
            cnt_n   = dur(next_of(state_q));
          end else if ((state_q == NS_G || state_q == EW_G) &&
                       ped_pend_q && cnt_q > 4'd2) begin
            cnt_n = 4'd2;
          end else begin
            cnt_n = cnt_q - 4'd1;
          end
        end
      end
      FLASH: begin
        if (tick) begin
          if (night_s) begin
            phase_n = ~phase_q;
            cnt_n   = 4'd0;
          end else begin
            state_n = AR1;
            cnt_n   = AR_CNT;
          end
        end
      end
      default: begin
        state_n = NS_G;
        cnt_n   = G_CNT;
        phase_n = 1'b0;
      end
    endcase

    // A request arriving in the same cycle as an all-red entry must not be lost.
    ped_pend_n = ped_pend_q;
    if ((state_n == AR1 || state_n == AR2) && state_n != state_q)
      ped_pend_n = 1'b0;
    if (ped_s)
      ped_pend_n = 1'b1;
  end

  // Lamp decode from the current state and flash phase.
  always_comb begin
    ns_light_o = LAMP_R;
    ew_light_o = LAMP_R;
    case (state_q)
      NS_G:  ns_light_o = LAMP_G;
      NS_Y:  ns_light_o = LAMP_Y;
      EW_G:  ew_light_o = LAMP_G;
      EW_Y:  ew_light_o = LAMP_Y;
      FLASH: begin
        ns_light_o = phase_q ? LAMP_Y : LAMP_OFF;
        ew_light_o = phase_q ? LAMP_Y : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign cnt_o   = cnt_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed scenarios followed by
// random pedestrian / night stimulus, all compared against a tick-level
// behavioural model of the light sequence.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       slow_clk;
  logic       ped_req;
  logic       night;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [3:0] cnt;
  logic [2:0] state;

  traffic_light_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .slow_clk_i (slow_clk),
    .ped_req_i  (ped_req),
    .night_i    (night),
    .ns_light_o (ns_light),
    .ew_light_o (ew_light),
    .cnt_o      (cnt),
    .state_o    (state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: state number 0..5 in cycle order, 6 = flashing.
  int m_state, m_cnt, m_ped, m_phase, m_night;
  int         dur_tab[6] = '{8, 2, 1, 8, 2, 1};
  logic [2:0] ns_tab[6]  = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab[6]  = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_lamp(input bit is_ns);
    if (m_state == 6) return m_phase != 0 ? 3'b010 : 3'b000;
    return is_ns ? ns_tab[m_state] : ew_tab[m_state];
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(state), 32'(m_state));
    check({tag, ".cnt"},   32'(cnt),   32'(m_cnt));
    check({tag, ".ns"},    32'(ns_light), 32'(exp_lamp(1'b1)));
    check({tag, ".ew"},    32'(ew_light), 32'(exp_lamp(1'b0)));
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 8; m_ped = 0; m_phase = 0; m_night = 0;
  endtask

  // One slow-clock tick applied to the model.
  task automatic model_tick();
    if (m_state == 6) begin
      if (m_night != 0) begin
        m_phase = 1 - m_phase;
        m_cnt   = 0;
      end else begin
        m_state = 2; m_cnt = dur_tab[2]; m_ped = 0;
      end
    end else if (m_night != 0) begin
      m_state = 6; m_cnt = 0; m_phase = 1;
    end else if (m_cnt == 1) begin
      m_state = (m_state + 1) % 6;
      m_cnt   = dur_tab[m_state];
      if (m_state == 2 || m_state == 5) m_ped = 0;
    end else if ((m_state == 0 || m_state == 3) && m_ped != 0 && m_cnt > 2) begin
      m_cnt = 2;
    end else begin
      m_cnt = m_cnt - 1;
    end
  endtask

  // One full slow-clock period with random high/low lengths, then compare.
  task automatic do_tick(input string tag);
    slow_clk = 1'b1;
    repeat ($urandom_range(4, 9)) @(negedge clk);
    slow_clk = 1'b0;
    repeat ($urandom_range(4, 9)) @(negedge clk);
    model_tick();
    check_all(tag);
  endtask

  task automatic pulse_ped();
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    repeat (3) @(negedge clk);
    m_ped = 1;
  endtask

  task automatic set_night(input logic v);
    night = v;
    repeat (4) @(negedge clk);
    m_night = int'(v);
  endtask

  task automatic apply_reset();
    rst = 1'b1; slow_clk = 1'b0; ped_req = 1'b0; night = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check_all("rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; slow_clk = 1'b0; ped_req = 1'b0; night = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.ns",    32'(ns_light), 32'd1);
    check("reset.ew",    32'(ew_light), 32'd4);
    check("reset.cnt",   32'(cnt),      32'd8);
    check("reset.state", 32'(state),    32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Plain cycle with no requests.
    for (int i = 0; i < 30; i++) do_tick("cycle");

    // Pedestrian request at cnt=6 shortens the NS green to 2.
    apply_reset();
    do_tick("ped6"); do_tick("ped6");
    check("ped6.pre", 32'(cnt), 32'd6);
    pulse_ped();
    do_tick("ped6");
    check("ped6.short", 32'(cnt), 32'd2);
    for (int i = 0; i < 6; i++) do_tick("ped6.after");
    check("ped6.ewg_full", 32'(cnt), 32'd7);

    // Request at cnt=2 does not shorten further.
    apply_reset();
    for (int i = 0; i < 6; i++) do_tick("ped2");
    pulse_ped();
    do_tick("ped2");
    check("ped2.cnt1", 32'(cnt), 32'd1);
    do_tick("ped2");
    check("ped2.nsy", 32'(state), 32'd1);

    // Night mode entered from EW green, flashing, then exit through AR1.
    while (m_state != 3) do_tick("to_ewg");
    do_tick("ewg");
    set_night(1'b1);
    do_tick("night");
    check("night.state", 32'(state), 32'd6);
    check("night.lamp",  32'({ns_light, ew_light}), 32'(6'b010010));
    for (int i = 0; i < 4; i++) do_tick("flash");
    set_night(1'b0);
    do_tick("exit");
    check("exit.ar1", 32'({state, cnt}), 32'({3'd2, 4'd1}));
    do_tick("exit");
    check("exit.ewg", 32'({state, cnt}), 32'({3'd3, 4'd8}));

    // Night and pedestrian together: flashing wins, no shortening.
    apply_reset();
    ped_req = 1'b1; night = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    repeat (4) @(negedge clk);
    m_ped = 1; m_night = 1;
    do_tick("both");
    night = 1'b0;
    repeat (4) @(negedge clk);
    m_night = 0;
    do_tick("both.ar1");
    do_tick("both.ewg");
    do_tick("both.ewg7");

    // Asynchronous reset mid-NS_Y with slow clock held high.
    apply_reset();
    for (int i = 0; i < 8; i++) do_tick("to_nsy");
    slow_clk = 1'b1;
    repeat (5) @(negedge clk);
    model_tick();
    check_all("nsy_mid");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_all("stuck_high");
    slow_clk = 1'b0;
    repeat (5) @(negedge clk);
    do_tick("fresh_edge");

    // Randomized pedestrian and night activity.
    apply_reset();
    for (int i = 0; i < 250; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 15) pulse_ped();
      else if (r < 22) set_night(m_night == 0);
      do_tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
